// File: rtl/ternary_alu_result_fifo_pkg.sv
// Shared ternary datapath types: trit encoding width and the captured ALU result record.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam int unsigned ALU_RESULT_W = 20;

  typedef struct packed {
    trit_t [7:0] result;
    trit_t       carry;
    logic        zero;
    logic        neg;
  } alu_result_t;

endpackage

// File: rtl/ternary_alu_result_fifo.sv
// First-word-fall-through result buffer behind the pipelined ternary ALU, with
// almost-full throttling and sticky overflow/drop accounting.
module ternary_alu_result_fifo
  import ternary_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [15:0]              in_result,
  input  logic [1:0]               in_carry,
  input  logic                     in_zero,
  input  logic                     in_neg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic [1:0]               out_carry,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     clear_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_almost_full;
  logic          r_overflow;
  logic [7:0]    r_drop_count;

  alu_result_t   r_mem [DEPTH];
  alu_result_t   w_in_entry;
  alu_result_t   w_head;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_in_entry = alu_result_t'({in_result, in_carry, in_zero, in_neg});

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_pop       = (r_count != '0) && out_ready;
    w_push      = in_valid && (!w_full || w_pop);
    w_drop      = in_valid && w_full && !w_pop;
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count       <= w_count_nxt;
      r_almost_full <= ((CW'(DEPTH) - w_count_nxt) <= CW'(AF_MARGIN));
      // A drop in the same cycle as a clear leaves exactly that one drop recorded.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (clear_overflow) begin
          r_drop_count <= 8'd1;
        end else if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end else if (clear_overflow) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign out_valid   = (r_count != '0);
  assign out_result  = out_valid ? w_head.result : '0;
  assign out_carry   = out_valid ? w_head.carry  : '0;
  assign out_zero    = out_valid ? w_head.zero   : 1'b0;
  assign out_neg     = out_valid ? w_head.neg    : 1'b0;
  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_ternary_alu_result_fifo.sv
// Scoreboard bench for ternary_alu_result_fifo: ordering, thresholds, overflow and reset.
module tb_ternary_alu_result_fifo;

  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_result;
  logic [1:0]  in_carry;
  logic        in_zero;
  logic        in_neg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [1:0]  out_carry;
  logic        out_zero;
  logic        out_neg;
  logic [3:0]  count;
  logic        almost_full;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clear_overflow;

  ternary_alu_result_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_result      (in_result),
    .in_carry       (in_carry),
    .in_zero        (in_zero),
    .in_neg         (in_neg),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_carry      (out_carry),
    .out_zero       (out_zero),
    .out_neg        (out_neg),
    .count          (count),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_overflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  logic [19:0] q[$];
  int          m_count = 0;
  logic        m_ovf   = 1'b0;
  int          m_drops = 0;
  logic        did_pop;
  logic        pre_valid;
  logic [19:0] pop_exp;
  logic [19:0] pop_act;

  function automatic logic m_af();
    return (DEPTH - m_count) <= AF_MARGIN;
  endfunction

  // Drive one cycle and advance the reference model; sampling happens before the edge.
  task automatic drive(input logic v, input logic [19:0] d, input logic rdy, input logic clr);
    logic pop;
    in_valid = v;
    {in_result, in_carry, in_zero, in_neg} = d;
    out_ready = rdy;
    clear_overflow = clr;
    pop = (m_count != 0) && rdy;
    pre_valid = out_valid;
    did_pop = pop;
    pop_act = {out_result, out_carry, out_zero, out_neg};
    if (pop) pop_exp = q.pop_front();
    if (v && (m_count < DEPTH || pop)) q.push_back(d);
    if (v && m_count == DEPTH && !pop) begin
      m_ovf = 1'b1;
      m_drops = clr ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    m_count = q.size();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    {in_result, in_carry, in_zero, in_neg} = '0;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    #12;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl count=%0d valid=%b af=%b expected 0 0 0", count, out_valid, almost_full);
    end
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0 || out_result !== 16'd0) begin
      errors++;
      $display("FAIL reset_flags ovf=%b drops=%0d res=%h expected 0 0 0", overflow, drop_count, out_result);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    drive(1'b1, {16'h0001, 2'b01, 1'b0, 1'b0}, 1'b0, 1'b0);
    checks++;
    if (pre_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass out_valid=%b expected 0", pre_valid);
    end
    drive(1'b1, {16'h0004, 2'b00, 1'b0, 1'b0}, 1'b0, 1'b0);
    drive(1'b1, {16'h0010, 2'b10, 1'b0, 1'b0}, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd3 || out_result !== 16'h0001 || out_carry !== 2'b01 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_head count=%0d res=%h carry=%b valid=%b expected 3 0001 01 1",
               count, out_result, out_carry, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (!did_pop || pop_act !== pop_exp) begin
        errors++;
        $display("FAIL basic_pop%0d got=%h expected=%h popped=%b", i, pop_act, pop_exp, did_pop);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || {out_result, out_carry, out_zero, out_neg} !== 20'd0 || count !== 4'd0) begin
      errors++;
      $display("FAIL basic_empty valid=%b data=%h count=%0d expected 0 0 0",
               out_valid, {out_result, out_carry, out_zero, out_neg}, count);
    end
  endtask

  task automatic test_almost_full();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 20'($urandom), 1'b0, 1'b0);
      checks++;
      if (almost_full !== m_af() || count !== 4'(m_count)) begin
        errors++;
        $display("FAIL af_fill%0d af=%b count=%0d expected %b %0d", i, almost_full, count, m_af(), m_count);
      end
    end
    checks++;
    if (almost_full !== 1'b1) begin
      errors++;
      $display("FAIL af_at6 af=%b expected 1", almost_full);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (almost_full !== 1'b0 || count !== 4'd5 || pop_act !== pop_exp) begin
      errors++;
      $display("FAIL af_pop af=%b count=%0d data=%h expected 0 5 %h", almost_full, count, pop_act, pop_exp);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) drive(1'b1, 20'($urandom), 1'b0, 1'b0);
    checks++;
    if (count !== 4'd8 || almost_full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full count=%0d af=%b ovf=%b expected 8 1 0", count, almost_full, overflow);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 20'($urandom), 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd3 || count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_drops ovf=%b drops=%0d count=%0d expected 1 3 8", overflow, drop_count, count);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (!did_pop || pop_act !== pop_exp) begin
        errors++;
        $display("FAIL ovf_drain%0d got=%h expected=%h", i, pop_act, pop_exp);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 8'd3) begin
      errors++;
      $display("FAIL ovf_sticky valid=%b ovf=%b drops=%0d expected 0 1 3", out_valid, overflow, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_only ovf=%b drops=%0d expected 0 0", overflow, drop_count);
    end
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 20'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 20'($urandom), 1'b1, 1'b0);
      checks++;
      if (pop_act !== pop_exp || count !== 4'd8 || drop_count !== 8'd0) begin
        errors++;
        $display("FAIL b2b%0d data=%h count=%0d drops=%0d expected %h 8 0",
                 i, pop_act, count, drop_count, pop_exp);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (pop_act !== pop_exp) begin
        errors++;
        $display("FAIL b2b_drain%0d got=%h expected=%h", i, pop_act, pop_exp);
      end
    end
  endtask

  task automatic test_clear_race();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 20'($urandom), 1'b0, 1'b0);
    drive(1'b1, 20'($urandom), 1'b0, 1'b1);
    checks++;
    if (overflow !== m_ovf || drop_count !== 8'(m_drops) || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL clear_race ovf=%b drops=%0d expected 1 1", overflow, drop_count);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0 || count !== 4'd8) begin
      errors++;
      $display("FAIL clear_after ovf=%b drops=%0d count=%0d expected 0 0 8", overflow, drop_count, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (pop_act !== pop_exp) begin
        errors++;
        $display("FAIL race_drain%0d got=%h expected=%h", i, pop_act, pop_exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] d;
    for (int i = 0; i < 5; i++) drive(1'b1, 20'($urandom), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || out_result !== 16'd0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset count=%0d valid=%b res=%h af=%b expected 0 0 0 0",
               count, out_valid, out_result, almost_full);
    end
    q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    m_drops = 0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d = {16'h2A5A, 2'b10, 1'b1, 1'b0};
    drive(1'b1, d, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || {out_result, out_carry, out_zero, out_neg} !== d || count !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_push valid=%b data=%h count=%0d expected 1 %h 1",
               out_valid, {out_result, out_carry, out_zero, out_neg}, count, d);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (pop_act !== pop_exp || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pop data=%h valid=%b expected %h 0", pop_act, out_valid, pop_exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_almost_full();
    test_overflow();
    test_back_to_back();
    test_clear_race();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ternary_alu_result_fifo.md
# ternary_alu_result_fifo

Buffers the outputs of the pipelined ternary ALU, which has no backpressure, and hands them to a consumer over a valid/ready interface. Each capture holds the 8-trit result, carry trit and flags. The block also provides an almost-full indication so the command source can throttle `valid_in`, and it accounts for any result lost to overflow. It sits directly downstream of the ALU top, between the ALU's binary output interface and the host readout / UART bridge.

## Interface
- `DEPTH`, 8 — entry count; power of two, ≥ 2.
- `AF_MARGIN`, 2 — `almost_full` asserts when free entries ≤ `AF_MARGIN`; range 1..`DEPTH`-1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  ALU result strobe (connects to ALU `valid_out`).
- `in_result`  in  16  8 trits, 2 bits per trit; trit i occupies bits [2i+1:2i].
- `in_carry`  in  2  carry trit.
- `in_zero`  in  1  ALU zero flag.
- `in_neg`  in  1  ALU negative flag.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_result`  out  16  head entry result.
- `out_carry`  out  2  head entry carry.
- `out_zero`  out  1  head entry zero flag.
- `out_neg`  out  1  head entry negative flag.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `almost_full`  out  1  `DEPTH - count ≤ AF_MARGIN`.
- `overflow`  out  1  sticky; set when a result is dropped.
- `drop_count`  out  8  dropped results; saturates at 255.
- `clear_overflow`  in  1  synchronous clear of `overflow` and `drop_count`.

## Operation
- Push: `in_valid`=1 and (`count` < `DEPTH`, or a pop occurs in the same cycle). The 20-bit entry is written at `wr_ptr`, and `wr_ptr` increments modulo `DEPTH`.
- Pop: `out_valid` && `out_ready`. `rd_ptr` increments modulo `DEPTH`.
- Drop: `in_valid`=1 with `count`==`DEPTH` and no pop in that cycle. No write occurs. `overflow` is set to 1 and `drop_count` increments, saturating at 255.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Read side is first-word-fall-through. `out_valid` = (`count` != 0), and `out_*` show the entry at `rd_ptr`.
- When empty, all `out_*` data outputs are forced to 0.
- Data is passed through as opaque bits; the block performs no trit decoding or validation.
- Empty: there is no bypass, so a push into an empty FIFO does not appear on `out_*` in the same cycle.
- Full with pop: the push is accepted and `count` stays at `DEPTH`.
- `clear_overflow` together with a drop in the same cycle: the drop wins. Result is `overflow`=1, `drop_count`=1.
- `clear_overflow` with no drop: `overflow`=0 and `drop_count`=0 on the next edge.
- Pointers are `$clog2(DEPTH)` bits wide; wrap is natural binary overflow.
- `count` carries one extra bit so that full and empty are unambiguous.

## Timing
- Reset is asynchronous. The following all go to 0 immediately: `wr_ptr`, `rd_ptr`, `count`, `out_valid`, all `out_*` data, `almost_full`, `overflow`, `drop_count`.
- Storage contents are not reset; the zero gating on the outputs hides them.
- Reset mid-operation discards all buffered entries. The first `in_valid` after release is accepted normally.
- Write-to-visible latency is 1 cycle: a push at edge N gives `out_valid`=1 with that data after edge N.
- `count`, `almost_full`, `overflow` and `drop_count` are registered and update on the edge that performs the push, pop or drop.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- `out_ready` may be held high continuously. `out_*` must not change while `out_valid`=1 and `out_ready`=0.

## Structure
- Add `alu_result_t` to `ternary_pkg`: a packed struct of `result` (trit_t[7:0]), `carry` (trit_t), `zero`, `neg`; 20 bits total.
- Add `ALU_RESULT_W` = 20 to `ternary_pkg`.
- The storage array is of type `alu_result_t`. The ports stay as flat binary vectors, converted at the boundary, to match the ALU top.
- No sub-module is needed: one module holds the pointers, counter, storage and flag logic.
- Top-level integration places the block after `ternary_alu_top_pipelined` and feeds `almost_full` back to the command source.

## Test plan
- Reset, then push 3 results (0x0001/2'b01, 0x0004/2'b00, 0x0010/2'b10) with `out_ready`=0 → `count`=3, `out_result`=0x0001. Then set `out_ready`=1 → results pop in order over 3 cycles, after which `out_valid`=0 and `out_*`=0.
- With `DEPTH`=8 and `AF_MARGIN`=2: push 6 → `almost_full`=1 exactly on the edge that makes `count`=6. Pop 1 → `almost_full`=0.
- Fill to 8, then apply 3 more `in_valid` pulses with `out_ready`=0 → `overflow`=1, `drop_count`=3, and the stored contents are unchanged.
- Full FIFO with `in_valid` and `out_ready` both high for 10 cycles → `count` stays 8, `drop_count` stays 0, and output order is preserved across pointer wrap.
- Assert `clear_overflow` in the same cycle as a drop → `overflow`=1, `drop_count`=1. Next cycle apply `clear_overflow` alone → both read 0.
- Assert `rst_n`=0 asynchronously with 5 entries buffered → `count`=0 and `out_valid`=0 before the next edge. After release, a single push appears at the head.
